mem_copy_engine: RTL and testbench

- Bus master that drives the data_mem port (DataAddress, ReadMem, WriteMem, DataIn, DataOut) as the initiator side of that interface.
- On a Start pulse it either copies Length bytes from SrcAddr to DstAddr with overlap-safe (memmove) semantics, or fills Length bytes at DstAddr with FillVal.
- It sits beside the core and takes over the data-memory port for block moves and memory initialisation; muxing with the core's port is outside this block.

---
 rtl/mem_copy_pkg.sv | 10 +
 rtl/mem_copy_engine_if.sv | 14 +
 rtl/mem_copy_engine.sv | 121 ++++++++++++
 tb/tb_mem_copy_engine.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the block-move / fill engine.
package mem_copy_pkg;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
endpackage

// File: rtl/mem_copy_engine_if.sv
// data_mem port bundle; the engine is the master, the memory the slave.
interface mem_copy_engine_if #(
  parameter int AW = 8,
  parameter int DW = 8
) ();
  logic [AW-1:0] DataAddress;
  logic          ReadMem;
  logic          WriteMem;
  logic [DW-1:0] DataIn;
  logic [DW-1:0] DataOut;

  modport master (output DataAddress, ReadMem, WriteMem, DataIn, input DataOut);
  modport slave  (input DataAddress, ReadMem, WriteMem, DataIn, output DataOut);
endinterface

// File: rtl/mem_copy_engine.sv
// Memmove-safe byte copy / memory fill engine driving the data_mem port.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               Start,
  input  logic               Mode,
  input  logic [AW-1:0]      SrcAddr,
  input  logic [AW-1:0]      DstAddr,
  input  logic [AW-1:0]      Length,
  input  logic [DW-1:0]      FillVal,
  output logic               Busy,
  output logic               Done,
  mem_copy_engine_if.master  mem
);

  state_t        r_state, w_nstate;
  logic          r_mode, r_back;
  logic [DW-1:0] r_fill, r_buf;
  logic [AW-1:0] r_cnt, r_src, r_dst;

  logic [AW:0]   w_src_end;
  logic          w_back;
  logic [AW-1:0] w_len_m1;
  logic [AW-1:0] w_addr;
  logic          w_rd, w_wr;
  logic [DW-1:0] w_wdata;

  // Overlap test uses one extra bit so a source range running past the top
  // of memory is not mistaken for a non-overlapping one.
  assign w_src_end = {1'b0, SrcAddr} + {1'b0, Length};
  assign w_back    = (Mode == MODE_COPY) && (DstAddr > SrcAddr) &&
                     ({1'b0, DstAddr} < w_src_end);
  assign w_len_m1  = Length - 1'b1;

  always_ff @(posedge CLK) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    Busy     = 1'b0;
    Done     = 1'b0;
    w_rd     = 1'b0;
    w_wr     = 1'b0;
    w_addr   = '0;
    w_wdata  = '0;
    case (r_state)
      IDLE: begin
        if (Start) begin
          if (Length == '0)            w_nstate = DONE;
          else if (Mode == MODE_FILL)  w_nstate = WRITE;
          else                         w_nstate = READ;
        end
      end
      READ: begin
        Busy     = 1'b1;
        w_rd     = 1'b1;
        w_addr   = r_src;
        w_nstate = WRITE;
      end
      WRITE: begin
        Busy    = 1'b1;
        w_wr    = 1'b1;
        w_addr  = r_dst;
        w_wdata = (r_mode == MODE_FILL) ? r_fill : r_buf;
        if (r_cnt == AW'(1))         w_nstate = DONE;
        else if (r_mode == MODE_FILL) w_nstate = WRITE;
        else                          w_nstate = READ;
      end
      DONE: begin
        Done     = 1'b1;
        w_nstate = IDLE;
      end
      default: w_nstate = IDLE;
    endcase
  end

  assign mem.DataAddress = w_addr;
  assign mem.ReadMem     = w_rd;
  assign mem.WriteMem    = w_wr;
  assign mem.DataIn      = w_wdata;

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_mode <= MODE_COPY;
      r_back <= 1'b0;
      r_fill <= '0;
      r_buf  <= '0;
      r_cnt  <= '0;
      r_src  <= '0;
      r_dst  <= '0;
    end else begin
      case (r_state)
        IDLE: if (Start) begin
          r_mode <= Mode;
          r_back <= w_back;
          r_fill <= FillVal;
          r_cnt  <= Length;
          r_src  <= w_back ? SrcAddr + w_len_m1 : SrcAddr;
          r_dst  <= w_back ? DstAddr + w_len_m1 : DstAddr;
        end
        READ: begin
          r_buf <= mem.DataOut;
          r_src <= r_back ? r_src - 1'b1 : r_src + 1'b1;
        end
        WRITE: begin
          r_dst <= r_back ? r_dst - 1'b1 : r_dst + 1'b1;
          r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed + random checks of mem_copy_engine against a memmove/fill model.
module tb_mem_copy_engine;
  import mem_copy_pkg::*;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       Start = 1'b0;
  logic       Mode = 1'b0;
  logic [7:0] SrcAddr = '0, DstAddr = '0, Length = '0, FillVal = '0;
  logic       Busy, Done;

  logic [7:0] mem_arr [256];
  logic [7:0] exp_mem [256];
  logic       pl_we = 1'b0;
  logic [7:0] pl_addr = '0, pl_data = '0;

  int n_assert = 0;
  int n_fail   = 0;

  // per-command observations
  int busy_n, rd_n, wr_n, done_k, extra_done, alt_err, both_err, idle_nz;
  int first_rd, first_wr;

  mem_copy_engine_if #(.AW(8), .DW(8)) bus ();

  mem_copy_engine #(.AW(8), .DW(8)) dut (
    .CLK(CLK), .reset(reset), .Start(Start), .Mode(Mode),
    .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Length(Length), .FillVal(FillVal),
    .Busy(Busy), .Done(Done), .mem(bus.master)
  );

  always #5 CLK = ~CLK;

  // data_mem: combinational read, write on rising edge
  assign bus.DataOut = mem_arr[bus.DataAddress];
  always @(posedge CLK) begin
    if (bus.WriteMem === 1'b1) mem_arr[bus.DataAddress] <= bus.DataIn;
    else if (pl_we)            mem_arr[pl_addr] <= pl_data;
  end

  task automatic chk(input string tag, input int obs, input int expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic poke(input int a, input int d);
    @(negedge CLK);
    pl_we = 1'b1; pl_addr = 8'(a); pl_data = 8'(d);
    exp_mem[a & 255] = 8'(d);
    @(negedge CLK);
    pl_we = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    int diffs = 0;
    for (int i = 0; i < 256; i++)
      if (mem_arr[i] !== exp_mem[i]) diffs++;
    chk(tag, diffs, 0);
  endtask

  function automatic void model(input logic m, input int src, input int dst,
                                input int len, input int fill);
    logic [7:0] tmp [256];
    if (m == MODE_FILL) begin
      for (int i = 0; i < len; i++) exp_mem[(dst + i) & 255] = 8'(fill);
    end else begin
      for (int i = 0; i < len; i++) tmp[i] = exp_mem[(src + i) & 255];
      for (int i = 0; i < len; i++) exp_mem[(dst + i) & 255] = tmp[i];
    end
  endfunction

  // Issue one command and observe it cycle by cycle at the falling edge.
  // inject_k > 0 raises a second Start with Dst=100 in that busy cycle.
  task automatic run(input logic m, input int src, input int dst, input int len,
                     input int fill, input int inject_k);
    busy_n = 0; rd_n = 0; wr_n = 0; done_k = 0; extra_done = 0;
    alt_err = 0; both_err = 0; idle_nz = 0; first_rd = -1; first_wr = -1;
    @(negedge CLK);
    Mode = m; SrcAddr = 8'(src); DstAddr = 8'(dst); Length = 8'(len);
    FillVal = 8'(fill); Start = 1'b1;
    for (int k = 1; k <= 600; k++) begin
      @(negedge CLK);
      Start = (inject_k != 0 && k == inject_k);
      if (Start) DstAddr = 8'd100;
      if (Busy) begin
        busy_n++;
        if (m == MODE_COPY) begin
          if (bus.ReadMem !== k[0] || bus.WriteMem !== !k[0]) alt_err++;
        end else if (bus.ReadMem !== 1'b0 || bus.WriteMem !== 1'b1) alt_err++;
      end
      if (bus.ReadMem === 1'b1) begin
        rd_n++;
        if (first_rd < 0) first_rd = int'(bus.DataAddress);
      end
      if (bus.WriteMem === 1'b1) begin
        wr_n++;
        if (first_wr < 0) first_wr = int'(bus.DataAddress);
      end
      if (bus.ReadMem === 1'b1 && bus.WriteMem === 1'b1) both_err++;
      if (bus.ReadMem !== 1'b1 && bus.WriteMem !== 1'b1 &&
          (bus.DataAddress !== 8'd0 || bus.DataIn !== 8'd0)) idle_nz++;
      if (Done === 1'b1) begin
        done_k = k;
        if (Busy !== 1'b0) alt_err++;
        break;
      end
    end
    Start = 1'b0;
    if (done_k == 0) chk("done_timeout", 0, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (Done !== 1'b0 || Busy !== 1'b0) extra_done++;
    end
  endtask

  task automatic common_checks(input string tag, input logic m, input int len);
    int exp_done = (len == 0) ? 1 : (m == MODE_COPY ? 2 * len + 1 : len + 1);
    chk({tag, "_done_cycle"}, done_k, exp_done);
    chk({tag, "_busy_cycles"}, busy_n, exp_done - 1);
    chk({tag, "_reads"}, rd_n, (m == MODE_COPY) ? len : 0);
    chk({tag, "_writes"}, wr_n, len);
    chk({tag, "_seq_err"}, alt_err + both_err + idle_nz + extra_done, 0);
    check_mem({tag, "_mem"});
  endtask

  initial begin
    int len, src, dst, off, fill;
    logic m;

    repeat (3) @(negedge CLK);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_bus", int'({bus.ReadMem, bus.WriteMem, bus.DataAddress, bus.DataIn}), 0);
    reset = 1'b0;

    for (int i = 0; i < 256; i++) poke(i, $urandom_range(0, 255));

    // forward copy
    poke(15, 3); poke(16, 5); poke(17, 9);
    model(MODE_COPY, 15, 32, 3, 0);
    run(MODE_COPY, 15, 32, 3, 0, 0);
    common_checks("fwd", MODE_COPY, 3);
    chk("fwd_first_rd", first_rd, 15);
    chk("fwd_dst34", int'(mem_arr[34]), 9);

    // overlapping backward copy
    poke(40, 1); poke(41, 2); poke(42, 3); poke(43, 4);
    model(MODE_COPY, 40, 42, 4, 0);
    run(MODE_COPY, 40, 42, 4, 0, 0);
    common_checks("bwd", MODE_COPY, 4);
    chk("bwd_first_rd", first_rd, 43);
    chk("bwd_first_wr", first_wr, 45);
    chk("bwd_dst42", int'(mem_arr[42]), 1);

    // fill with address wrap
    model(MODE_FILL, 0, 254, 4, 8'hA5);
    run(MODE_FILL, 0, 254, 4, 8'hA5, 0);
    common_checks("fill", MODE_FILL, 4);
    chk("fill_mem0", int'(mem_arr[0]), 8'hA5);

    // zero length
    run(MODE_COPY, 10, 20, 0, 0, 0);
    common_checks("len0", MODE_COPY, 0);

    // Start while busy is ignored
    model(MODE_COPY, 60, 70, 5, 0);
    run(MODE_COPY, 60, 70, 5, 0, 3);
    common_checks("busy_start", MODE_COPY, 5);

    // reset after the 2nd write of a 5-byte copy
    model(MODE_COPY, 150, 160, 2, 0);
    @(negedge CLK);
    Mode = MODE_COPY; SrcAddr = 8'd150; DstAddr = 8'd160; Length = 8'd5; Start = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      Start = 1'b0;
    end
    chk("rst_mid_write2", int'(bus.WriteMem), 1);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    chk("rst_mid_outs", int'({Busy, Done, bus.ReadMem, bus.WriteMem, bus.DataAddress, bus.DataIn}), 0);
    done_k = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (Done || Busy || bus.ReadMem || bus.WriteMem) done_k++;
    end
    chk("rst_mid_quiet", done_k, 0);
    check_mem("rst_mid_mem");

    model(MODE_FILL, 0, 200, 6, 8'h3C);
    run(MODE_FILL, 0, 200, 6, 8'h3C, 0);
    common_checks("after_rst", MODE_FILL, 6);

    // random commands
    for (int t = 0; t < 12; t++) begin
      m = 1'($urandom_range(0, 1));
      if (m == MODE_FILL) begin
        len = $urandom_range(0, 30); dst = $urandom_range(0, 255);
        src = $urandom_range(0, 255); fill = $urandom_range(0, 255);
      end else begin
        len = $urandom_range(1, 24); fill = 0;
        src = $urandom_range(0, 256 - len);
        if ($urandom_range(0, 1) == 1) dst = $urandom_range(0, 256 - len);
        else begin
          off = $urandom_range(0, 2 * len - 2) - (len - 1);
          dst = src + off;
          if (dst < 0) dst = 0;
          if (dst > 256 - len) dst = 256 - len;
        end
      end
      model(m, src, dst, len, fill);
      run(m, src, dst, len, fill, 0);
      common_checks("rand", m, len);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
